// File: rtl/fir_multicycle_326.sv
// Time-multiplexed TAPSIZE-tap Q1.15 FIR: one shared multiplier and adder,
// one input sample and one output per TAPSIZE-cycle frame.
module fir_multicycle_326 #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TAPSIZE = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  localparam int unsigned PW     = (TAPSIZE > 1) ? $clog2(TAPSIZE) : 1;
  localparam int unsigned PRODW  = 2 * WIDTH;
  localparam logic [PW-1:0] P_LAST = PW'(TAPSIZE - 1);

  // Coefficients are loaded from outside the block; reset leaves them alone.
  logic [WIDTH-1:0] h_mem [0:TAPSIZE-1];

  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] d_q [0:TAPSIZE-1];
  logic [WIDTH-1:0] d_d [0:TAPSIZE-1];
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] y_q, y_d;

  logic signed [WIDTH-1:0] mul_a_c, mul_b_c;
  logic signed [PRODW-1:0] prod_c;
  logic [WIDTH-1:0]        term_c, addend_c, sum_c;

  // Shared MAC: frame start multiplies the incoming sample and restarts the sum.
  always_comb begin
    mul_a_c  = $signed(h_mem[p_q]);
    mul_b_c  = (p_q == '0) ? $signed(x) : $signed(d_q[p_q]);
    prod_c   = mul_a_c * mul_b_c;
    term_c   = WIDTH'(prod_c >>> (WIDTH - 1));
    addend_c = (p_q == '0) ? '0 : acc_q;
    sum_c    = addend_c + term_c;
  end

  always_comb begin
    p_d   = p_q;
    d_d   = d_q;
    acc_d = acc_q;
    y_d   = y_q;

    p_d   = (p_q == P_LAST) ? '0 : p_q + PW'(1);
    acc_d = sum_c;

    if (p_q == '0) begin
      d_d[0] = x;
      for (int k = 1; k < int'(TAPSIZE); k++) begin
        d_d[k] = d_q[k-1];
      end
    end

    if (p_q == P_LAST) begin
      y_d = sum_c;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      p_q   <= '0;
      acc_q <= '0;
      y_q   <= '0;
      for (int k = 0; k < int'(TAPSIZE); k++) begin
        d_q[k] <= '0;
      end
    end else begin
      p_q   <= p_d;
      d_q   <= d_d;
      acc_q <= acc_d;
      y_q   <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_fir_multicycle_326.sv
// Directed bench for fir_multicycle_326: frame-level reference model checked
// every cycle, plus literal expectations at each frame end.
module tb_fir_multicycle_326;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned TAPSIZE = 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [WIDTH-1:0] x   = '0;
  logic [WIDTH-1:0] y;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] coef [TAPSIZE];
  logic [WIDTH-1:0] hist [TAPSIZE];
  logic [WIDTH-1:0] exp_y = '0;
  int               ph    = 0;

  fir_multicycle_326 #(.WIDTH(WIDTH), .TAPSIZE(TAPSIZE)) dut (
    .CLK (CLK),
    .RST (RST),
    .x   (x),
    .y   (y)
  );

  always #5 CLK = ~CLK;

  // y[n] = sum of truncated products over the sample history, 16-bit wrap.
  function automatic logic [WIDTH-1:0] fir_out();
    logic signed [2*WIDTH-1:0] pr;
    logic [WIDTH-1:0]          s;
    s = '0;
    for (int k = 0; k < int'(TAPSIZE); k++) begin
      pr = $signed(coef[k]) * $signed(hist[k]);
      s  = s + WIDTH'(pr >>> (WIDTH - 1));
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: y=%h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic set_coefs(input logic [WIDTH-1:0] v);
    for (int k = 0; k < int'(TAPSIZE); k++) begin
      coef[k]          = v;
      dut.h_mem[k]     = v;
    end
  endtask

  // Reference: sample taken on each frame start, output published on the
  // last cycle of the frame and held for a whole frame.
  always @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < int'(TAPSIZE); k++) hist[k] <= '0;
      exp_y <= '0;
      ph    <= 0;
    end else begin
      if (ph == 0) begin
        hist[0] <= x;
        for (int k = 1; k < int'(TAPSIZE); k++) hist[k] <= hist[k-1];
      end
      if (ph == int'(TAPSIZE) - 1) exp_y <= fir_out();
      ph <= (ph + 1) % int'(TAPSIZE);
    end
  end

  always @(negedge CLK) begin
    check("model", y, exp_y);
  end

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic frame(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] lit,
                       input string name);
    x = xv;
    repeat (TAPSIZE) @(negedge CLK);
    check(name, y, lit);
  endtask

  initial begin
    set_coefs(16'h2AAA);
    x   = 16'h7FFF;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset", y, 16'h0000);
    RST = 1'b0;

    // Impulse; y must stay 0 until the last edge of the first frame.
    x = 16'h7FFF;
    @(negedge CLK);
    check("post_reset_e0", y, 16'h0000);
    @(negedge CLK);
    check("post_reset_e1", y, 16'h0000);
    @(negedge CLK);
    check("impulse0", y, 16'h2AA9);
    frame(16'h0000, 16'h2AA9, "impulse1");
    frame(16'h0000, 16'h2AA9, "impulse2");
    frame(16'h0000, 16'h0000, "impulse3");

    // Step from a cleared history.
    frame(16'h4000, 16'h1555, "step0");
    frame(16'h4000, 16'h2AAA, "step1");
    frame(16'h4000, 16'h3FFF, "step2");
    frame(16'h4000, 16'h3FFF, "step3");

    do_reset();
    frame(16'hC000, 16'hEAAB, "neg_c000_0");
    frame(16'hC000, 16'hD556, "neg_c000_1");
    frame(16'hC000, 16'hC001, "neg_c000_2");

    do_reset();
    frame(16'h8000, 16'hD556, "neg_8000_0");
    frame(16'h8000, 16'hAAAC, "neg_8000_1");
    frame(16'h8000, 16'h8002, "neg_8000_2");

    RST = 1'b1;
    set_coefs(16'h7FFF);
    do_reset();
    frame(16'h7FFF, 16'h7FFE, "wrap0");
    frame(16'h7FFF, 16'hFFFC, "wrap1");
    frame(16'h7FFF, 16'h7FFA, "wrap2");

    // Reset one edge into a frame, then restart the step sequence.
    RST = 1'b1;
    set_coefs(16'h2AAA);
    do_reset();
    frame(16'h4000, 16'h1555, "mr_step0");
    x = 16'h4000;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("mr_cleared", y, 16'h0000);
    RST = 1'b0;
    frame(16'h4000, 16'h1555, "mr_restart0");
    frame(16'h4000, 16'h2AAA, "mr_restart1");
    frame(16'h4000, 16'h3FFF, "mr_restart2");

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_multicycle_326.md
# fir_multicycle_326

Time-multiplexed 3-tap FIR filter on 16-bit Q1.15 signed samples. One shared multiplier and one accumulator compute one output every TAPSIZE clock cycles, so one input sample is taken per TAPSIZE-cycle frame. The block is a DSP datapath leaf. It has no handshake: the surrounding logic presents a new sample on `x` once per frame and reads `y` at the end of the frame.

## Interface
- `WIDTH`, 16: sample, coefficient and output width, Q1.15 two's complement.
- `TAPSIZE`, 3: number of taps, which is also the number of cycles per output.
- `CLK`  in  1  the single clock; all state updates on the rising edge.
- `RST`  in  1  reset; synchronous and active-high.
- `x`  in  WIDTH  input sample, Q1.15; sampled only on frame-start edges.
- `y`  out  WIDTH  filter output, Q1.15; registered; holds its value between updates.
- Internal coefficient array `h_mem[0:TAPSIZE-1]`, WIDTH bits each, Q1.15.
  - Must be a plain register array with exactly this name, so benches can load it hierarchically (e.g. `$readmemb` at time 0).
  - No initial block and no reset value; RST does not touch it.

## Operation
- Phase counter `p` counts 0..TAPSIZE-1 and wraps to 0. One full wrap is one frame.
- Delay line `d[0..TAPSIZE-1]`, WIDTH bits each. Accumulator `acc`, WIDTH bits.
- Product rule:
  - prod(a,b) = signed 16×16 → 32-bit Q2.30 result.
  - Take bits [30:15], i.e. arithmetic shift right by 15 with truncation toward −inf.
  - Result is Q1.15. No rounding, no saturation.
- Sums are 16-bit two's complement and wrap on overflow. There is no saturation.
- Edge with p==0 (frame start):
  - d[0] <= x; d[k] <= d[k-1] for k ≥ 1.
  - acc <= prod(h_mem[0], x).
- Edge with p==k, for 1 ≤ k ≤ TAPSIZE-2: acc <= acc + prod(h_mem[k], d[k]).
  - After the frame-start shift, d[k] holds x[n-k].
- Edge with p==TAPSIZE-1: y <= acc + prod(h_mem[TAPSIZE-1], d[TAPSIZE-1]).
  - acc may take the same value; it is cleared at the next frame start regardless.
- Result: y[n] = Σ h[k]·x[n-k], with the truncation and wrap rules above applied to each product and each partial sum.
- Exactly one multiplier instance and one adder are shared across all phases.

## Timing
- Reset (RST=1 at an edge):
  - p=0, all d=0, acc=0, y=0.
  - After reset release, the first edge is a frame start.
- Throughput: one new output per TAPSIZE cycles.
- Latency:
  - x is captured at the frame-start edge E.
  - y reflecting that sample updates at edge E+TAPSIZE-1 and stays stable until edge E+2·TAPSIZE-1.
- Input hold requirement: x must be stable at each frame-start edge. Changes at other times are ignored.
- Reset mid-frame: the frame is abandoned, y returns to 0 and the delay history is cleared. The next edge after release is a frame start.
- Coefficients loaded or changed mid-frame take effect at the phase in which they are read.

## Test plan
- Reset: hold RST=1 for 2 cycles with x=0x7FFF -> y=0x0000, and y stays 0 through the first TAPSIZE-1 edges after release.
- Impulse, h={0x2AAA,0x2AAA,0x2AAA}: x=0x7FFF for one frame, then 0 -> successive y = 0x2AA9, 0x2AA9, 0x2AA9, 0x0000.
  - Each y appears TAPSIZE-1 edges after its frame start.
- Step, same h: x=0x4000 held -> y = 0x1555, 0x2AAA, 0x3FFF, 0x3FFF…
  - Check as well that y is constant across each frame.
- Negative and truncation, same h:
  - x=0xC000 held -> y = 0xEAAB, 0xD556, 0xC001.
  - x=0x8000 held -> y = 0xD556, 0xAAAC, 0x8002.
- Wrap overflow, h all 0x7FFF: x=0x7FFF held -> y = 0x7FFE, then 0xFFFC (wrap, not saturate), then 0x7FFA.
- Mid-frame reset: during the step test, assert RST at phase 1 for one edge -> y=0 next edge. After release the sequence restarts at 0x1555 with no stale history.
